// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the single fifo_top write port between NUM_REQ producers.
// A grantee owns the port for one burst, which ends on last, on MAX_BURST words, or when it drops its request.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            last_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_i,
  input  logic                          full_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            ack_o,
  output logic                          fifo_wr_cs_o,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    owner_o
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        ptr_q, ptr_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 win_found;
  logic [OW-1:0]        win_idx;
  logic [OW-1:0]        cand;
  logic                 ack;
  logic                 burst_end;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= OW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Scan ptr+1, ptr+2, ... so the previous grantee is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = OW'((int'(ptr_q) + off) % NUM_REQ);
      if (!win_found && req_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ack       = 1'b0;
    burst_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[win_idx]   = 1'b1;
          owner_d          = win_idx;
          cnt_d            = '0;
        end
      end
      GRANT: begin
        ack = req_i[owner_q] & ~full_i;
        if (ack && (cnt_q != CW'(MAX_BURST))) begin
          cnt_d = cnt_q + CW'(1);
        end
        // Full stalls hold the grant indefinitely; only the owner's own signals end a burst.
        burst_end = ~req_i[owner_q] |
                    (ack & (last_i[owner_q] | (cnt_q == CW'(MAX_BURST - 1))));
        if (burst_end) begin
          state_d = IDLE;
          ptr_d   = owner_q;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ack_o          = '0;
    ack_o[owner_q] = ack;
    fifo_wr_en_o   = ack;
    fifo_wr_cs_o   = ack;
    fifo_data_o    = ack ? data_i[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign gnt_o   = gnt_q;
  assign busy_o  = (state_q == GRANT);
  assign owner_o = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level reference model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, last_i;
  logic [N*DW-1:0] data_i;
  logic            full_i;
  logic [N-1:0]    gnt_o, ack_o;
  logic            fifo_wr_cs_o, fifo_wr_en_o, busy_o;
  logic [DW-1:0]   fifo_data_o;
  logic [1:0]      owner_o;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .last_i       (last_i),
    .data_i       (data_i),
    .full_i       (full_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .fifo_wr_cs_o (fifo_wr_cs_o),
    .fifo_wr_en_o (fifo_wr_en_o),
    .fifo_data_o  (fifo_data_o),
    .busy_o       (busy_o),
    .owner_o      (owner_o)
  );

  always #5 clk = ~clk;

  int nAssert = 0;
  int nFail   = 0;

  // Reference model: who holds the port, how many words it has moved, who went last.
  bit mBusy;
  int mOwner;
  int mWords;
  int mLastGrantee;
  int seq [N];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp)
    else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] wordOf(input int i);
    return DW'(i * 256 + 'hA0 + seq[i]);
  endfunction

  task automatic modelReset();
    mBusy        = 1'b0;
    mOwner       = 0;
    mWords       = 0;
    mLastGrantee = N - 1;
    for (int i = 0; i < N; i++) seq[i] = 0;
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
    req_i  = r;
    last_i = l;
    full_i = f;
    for (int i = 0; i < N; i++) data_i[i*DW +: DW] = wordOf(i);
    #1;
  endtask

  task automatic checkOutput();
    logic [N-1:0]  eGnt, eAck;
    logic          eWr;
    logic [DW-1:0] eData;
    eGnt  = '0;
    eAck  = '0;
    eWr   = 1'b0;
    eData = '0;
    if (mBusy) begin
      eGnt[mOwner] = 1'b1;
      if (req_i[mOwner] && !full_i) begin
        eAck[mOwner] = 1'b1;
        eWr          = 1'b1;
        eData        = wordOf(mOwner);
      end
    end
    chk("gnt",   64'(gnt_o),        64'(eGnt));
    chk("ack",   64'(ack_o),        64'(eAck));
    chk("wr_en", 64'(fifo_wr_en_o), 64'(eWr));
    chk("wr_cs", 64'(fifo_wr_cs_o), 64'(eWr));
    chk("data",  64'(fifo_data_o),  64'(eData));
    chk("busy",  64'(busy_o),       64'(mBusy));
    chk("owner", 64'(owner_o),      64'(mOwner));
  endtask

  // Advance the model over one clock edge using the inputs currently applied.
  task automatic stepClock();
    @(posedge clk);
    if (!mBusy) begin
      for (int off = 1; off <= N; off++) begin
        int c;
        c = (mLastGrantee + off) % N;
        if (!mBusy && req_i[c]) begin
          mBusy  = 1'b1;
          mOwner = c;
          mWords = 0;
        end
      end
    end else if (!req_i[mOwner]) begin
      mBusy        = 1'b0;
      mLastGrantee = mOwner;
    end else if (!full_i) begin
      seq[mOwner]++;
      mWords++;
      if (last_i[mOwner] || mWords == MB) begin
        mBusy        = 1'b0;
        mLastGrantee = mOwner;
      end
    end
    #1;
  endtask

  task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic f);
    applyStimulus(r, l, f);
    checkOutput();
    stepClock();
  endtask

  task automatic doReset();
    rst    = 1'b0;
    req_i  = '0;
    last_i = '0;
    full_i = 1'b0;
    data_i = '0;
    modelReset();
    #3;
    chk("rst_gnt",   64'(gnt_o),        64'(0));
    chk("rst_busy",  64'(busy_o),       64'(0));
    chk("rst_wr",    64'(fifo_wr_en_o), 64'(0));
    chk("rst_owner", 64'(owner_o),      64'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int g [$];
    int n2;
    logic was;
    logic [N-1:0] r, l;

    rst = 1'b1;
    #2;

    $display("[TB] scenario: single 3-word burst");
    doReset();
    cycle(4'b0001, 4'b0000, 1'b0);
    chk("t1_gnt", 64'(gnt_o), 64'h1);
    for (int w = 0; w < 3; w++) begin
      applyStimulus(4'b0001, (w == 2) ? 4'b0001 : 4'b0000, 1'b0);
      chk("t1_wr",   64'(fifo_wr_en_o), 64'h1);
      chk("t1_data", 64'(fifo_data_o),  64'('hA0 + w));
      checkOutput();
      stepClock();
    end
    applyStimulus(4'b0000, 4'b0000, 1'b0);
    chk("t1_idle_gnt",  64'(gnt_o),  64'h0);
    chk("t1_idle_busy", 64'(busy_o), 64'h0);
    checkOutput();
    stepClock();

    $display("[TB] scenario: four-way rotation of 2-word bursts");
    doReset();
    for (int c = 0; c < 15; c++) begin
      for (int i = 0; i < N; i++) l[i] = (seq[i] % 2 == 1);
      applyStimulus(4'b1111, l, 1'b0);
      chk("t2_busy", 64'(busy_o), 64'((c % 3) != 0));
      if (c % 3 == 1) chk("t2_owner", 64'(owner_o), 64'(order[c/3]));
      checkOutput();
      stepClock();
    end

    $display("[TB] scenario: MAX_BURST cut-off");
    doReset();
    g.delete();
    n2 = 0;
    for (int c = 0; c < 30; c++) begin
      r = '0;
      r[2] = (seq[2] < 20);
      r[1] = (c > 0);
      l = '0;
      l[1] = (seq[1] % 2 == 1);
      was = busy_o;
      applyStimulus(r, l, 1'b0);
      if (g.size() == 1 && ack_o[2]) n2++;
      checkOutput();
      stepClock();
      if (busy_o && !was) g.push_back(int'(owner_o));
    end
    chk("t3_ngrants", 64'(g.size() >= 3), 64'h1);
    chk("t3_first",   64'(g[0]), 64'd2);
    chk("t3_second",  64'(g[1]), 64'd1);
    chk("t3_third",   64'(g[2]), 64'd2);
    chk("t3_acks2",   64'(n2),   64'd16);

    $display("[TB] scenario: full stall inside a burst");
    doReset();
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    cycle(4'b0001, 4'b0000, 1'b0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b1);
      chk("t4_stall_wr",  64'(fifo_wr_en_o), 64'h0);
      chk("t4_stall_ack", 64'(ack_o),        64'h0);
      chk("t4_stall_gnt", 64'(gnt_o),        64'h1);
      checkOutput();
      stepClock();
    end
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    chk("t4_resume_wr",   64'(fifo_wr_en_o), 64'h1);
    chk("t4_resume_data", 64'(fifo_data_o),  64'hA2);
    checkOutput();
    stepClock();
    for (int c = 3; c < MB; c++) begin
      applyStimulus(4'b0001, 4'b0000, 1'b0);
      chk("t4_in_burst", 64'(busy_o), 64'h1);
      checkOutput();
      stepClock();
    end
    applyStimulus(4'b0001, 4'b0000, 1'b0);
    chk("t4_ended", 64'(busy_o), 64'h0);
    checkOutput();
    stepClock();

    $display("[TB] scenario: owner abandons mid-burst");
    doReset();
    cycle(4'b0001, 4'b0000, 1'b0);
    for (int c = 0; c < 4; c++) cycle(4'b0101, 4'b0000, 1'b0);
    applyStimulus(4'b0100, 4'b0000, 1'b0);
    chk("t5_drop_wr",  64'(fifo_wr_en_o), 64'h0);
    chk("t5_drop_ack", 64'(ack_o),        64'h0);
    checkOutput();
    stepClock();
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    chk("t5_idle", 64'(busy_o), 64'h0);
    checkOutput();
    stepClock();
    applyStimulus(4'b0101, 4'b0000, 1'b0);
    chk("t5_owner", 64'(owner_o), 64'd2);
    chk("t5_gnt",   64'(gnt_o),   64'h4);
    checkOutput();
    stepClock();

    $display("[TB] scenario: asynchronous reset mid-burst");
    doReset();
    cycle(4'b0010, 4'b0000, 1'b0);
    cycle(4'b0010, 4'b0000, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b0);
    checkOutput();
    #1 rst = 1'b0;
    #1;
    chk("t6_gnt",  64'(gnt_o),        64'h0);
    chk("t6_wr",   64'(fifo_wr_en_o), 64'h0);
    chk("t6_busy", 64'(busy_o),       64'h0);
    chk("t6_ack",  64'(ack_o),        64'h0);
    modelReset();
    @(posedge clk);
    #1 rst = 1'b1;
    cycle(4'b1111, 4'b0000, 1'b0);
    chk("t6_owner", 64'(owner_o), 64'd0);
    chk("t6_first", 64'(gnt_o),   64'h1);

    $display("[TB] scenario: random traffic");
    doReset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++) begin
        r[i] = ($urandom_range(0, 9) < 7);
        l[i] = ($urandom_range(0, 5) == 0);
      end
      cycle(r, l, ($urandom_range(0, 4) == 0));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
